// File: rtl/bram_pkg.sv
// bram_pkg: shared constants, types and helpers for the single-port block RAM.
//   BRAM_NUM_LANES : number of write-strobe lanes per word
//   strobe_t       : one enable bit per lane
//   lane_width()   : lane width in bits for a given word width
package bram_pkg;

  localparam int unsigned BRAM_NUM_LANES = 8;

  typedef logic [BRAM_NUM_LANES-1:0] strobe_t;

  function automatic int unsigned lane_width(input int unsigned data_width);
    return data_width / BRAM_NUM_LANES;
  endfunction

endpackage

// File: rtl/bram_lane_sp.sv
// bram_lane_sp: one lane of a single-port, synchronous-read RAM.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears the read register only
//   we   : lane write enable (word write enable AND lane strobe)
//   addr : shared read/write word address
//   din  : lane write data
//   dout : registered lane read data (read-first on collision)
module bram_lane_sp #(
  parameter int unsigned LANE_W = 10,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LANE_W-1:0] din,
  output logic [LANE_W-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [LANE_W-1:0] mem [DEPTH];

  // Array write; contents are never touched by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  // Registered read; the non-blocking update gives read-first collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/bram_sp.sv
// bram_sp: single-port, synchronous-read block RAM with 8 per-lane write strobes.
// Optional feature macro: BRAM_SP_OUT_REG_EN adds an output pipeline register
// (read latency 2 instead of 1).
// Ports:
//   clk_i               : clock, rising edge
//   rst_i               : synchronous active-high reset, clears read data only
//   bram_we_i           : write enable for the addressed word
//   bram_write_strobe_i : lane enables, bit k covers bits [k*LANE_W +: LANE_W]
//   bram_addr_i         : word address shared by read and write
//   bram_din_i          : write data
//   bram_dout_o         : registered read data
module bram_sp
  import bram_pkg::*;
#(
  parameter int unsigned BRAM_DATA_WIDTH = 80,
  parameter int unsigned BRAM_ADDR_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       bram_we_i,
  input  strobe_t                    bram_write_strobe_i,
  input  logic [BRAM_ADDR_WIDTH-1:0] bram_addr_i,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_din_i,
  output logic [BRAM_DATA_WIDTH-1:0] bram_dout_o
);

  localparam int unsigned LANE_W = lane_width(BRAM_DATA_WIDTH);

  // Reject word widths that do not split evenly into lanes.
  if (BRAM_DATA_WIDTH % BRAM_NUM_LANES != 0) begin : g_width_check
    initial $fatal(1, "bram_sp: BRAM_DATA_WIDTH must be a multiple of 8");
  end

  logic [BRAM_DATA_WIDTH-1:0] rd_data;

  // One independent RAM per lane, all sharing clock and address.
  for (genvar k = 0; k < BRAM_NUM_LANES; k++) begin : g_lane
    bram_lane_sp #(
      .LANE_W (LANE_W),
      .ADDR_W (BRAM_ADDR_WIDTH)
    ) u_lane (
      .clk  (clk_i),
      .rst  (rst_i),
      .we   (bram_we_i & bram_write_strobe_i[k]),
      .addr (bram_addr_i),
      .din  (bram_din_i[k*LANE_W +: LANE_W]),
      .dout (rd_data[k*LANE_W +: LANE_W])
    );
  end

`ifdef BRAM_SP_OUT_REG_EN
  logic [BRAM_DATA_WIDTH-1:0] out_q;

  // Extra output stage to ease timing after the array read register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q <= '0;
    end else begin
      out_q <= rd_data;
    end
  end

  assign bram_dout_o = out_q;
`else
  assign bram_dout_o = rd_data;
`endif

endmodule

// File: tb/tb_bram_sp.sv
// tb_bram_sp: randomized self-checking bench for bram_sp against a word-array
// reference model with a read-latency pipeline.
module tb_bram_sp;
  import bram_pkg::*;

  localparam int unsigned DW    = 80;
  localparam int unsigned AW    = 8;
  localparam int unsigned LW    = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  strobe_t       strb;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain word array plus delayed read result.
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_q;
  logic [DW-1:0] stage_q;

  bram_sp #(
    .BRAM_DATA_WIDTH (DW),
    .BRAM_ADDR_WIDTH (AW)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .bram_we_i           (we),
    .bram_write_strobe_i (strb),
    .bram_addr_i         (addr),
    .bram_din_i          (din),
    .bram_dout_o         (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, compare the output.
  task automatic step(input logic r, input logic w, input strobe_t s,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    logic [DW-1:0] rd;
    rst  = r;
    we   = w;
    strb = s;
    addr = a;
    din  = d;
    @(posedge clk);
    rd = r ? '0 : mem_m[a];
    if (w) begin
      for (int k = 0; k < 8; k++) begin
        if (s[k]) mem_m[a][k*LW +: LW] = d[k*LW +: LW];
      end
    end
`ifdef BRAM_SP_OUT_REG_EN
    exp_q   = r ? '0 : stage_q;
    stage_q = rd;
`else
    exp_q = rd;
`endif
    #1;
    check(tag, dout, exp_q);
  endtask

  // Two idle reads of one address: output then reflects that address at either latency.
  task automatic settle(input logic [AW-1:0] a, input string tag);
    step(1'b0, 1'b0, 8'h00, a, '0, tag);
    step(1'b0, 1'b0, 8'h00, a, '0, tag);
  endtask

  localparam logic [DW-1:0] VAL_A = 80'h0123_4567_89AB_CDEF_1357;
  localparam logic [DW-1:0] VAL_P = 80'h0123_4567_89AB_CDEF_1000;
  localparam logic [DW-1:0] VAL_B = 80'hA5A5_5A5A_0F0F_F0F0_3C3C;

  initial begin
    logic [DW-1:0] rnd;
    rst = 1'b1; we = 1'b0; strb = '0; addr = '0; din = '0;
    stage_q = '0;
    exp_q   = '0;

    // Fill the array while held in reset: writes land, output stays zero.
    for (int i = 0; i < DEPTH; i++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      step(1'b1, 1'b1, 8'hFF, AW'(i), rnd, "reset_fill");
    end

    // Full write and readback.
    step(1'b0, 1'b1, 8'hFF, 8'h01, VAL_A, "full_wr");
    settle(8'h01, "full_rd");
    check("full_value", dout, VAL_A);

    // Partial strobe clears only lane 0.
    step(1'b0, 1'b1, 8'h01, 8'h01, '0, "part_wr");
    settle(8'h01, "part_rd");
    check("part_value", dout, VAL_P);

    // Read-first collision: old word out first, new word on re-read.
    step(1'b0, 1'b1, 8'hFF, 8'h01, VAL_B, "collide_wr");
    step(1'b0, 1'b0, 8'h00, 8'h01, '0, "collide_rd1");
    step(1'b0, 1'b0, 8'h00, 8'h01, '0, "collide_rd2");
    check("collide_new", dout, VAL_B);

    // Reset clears output, keeps contents.
    step(1'b1, 1'b0, 8'h00, 8'h01, '0, "rst_out");
    check("rst_zero", dout, '0);
    settle(8'h01, "rst_rd");
    check("rst_kept", dout, VAL_B);

    // Address extremes do not alias.
    step(1'b0, 1'b1, 8'hFF, 8'h00, 80'h1, "lo_wr");
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 80'h2, "hi_wr");
    settle(8'h00, "lo_rd");
    check("lo_value", dout, 80'h1);
    settle(8'hFF, "hi_rd");
    check("hi_value", dout, 80'h2);

    // Strobes ignored without write enable.
    step(1'b0, 1'b0, 8'hFF, 8'h00, {DW{1'b1}}, "we_gate");
    settle(8'h00, "we_gate_rd");
    check("we_gate_value", dout, 80'h1);

    // Randomized traffic, biased toward a few addresses for collisions.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      a   = ($urandom_range(0, 3) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 3));
      rnd = {$urandom(), $urandom(), $urandom()};
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 1) == 1),
           strobe_t'($urandom()), a, rnd, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
